// File: rtl/tmr_channel_array.sv
// tmr_channel_array: NUM_CH compare-match timers with a shared prescaler, bus registers, TMO pins and IRQs
module tmr_channel_array #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = $clog2(NUM_CH) + 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [BIT_WIDTH-1:0] wdata,
    output logic [BIT_WIDTH-1:0] rdata,
    input  logic [NUM_CH-1:0]    tmci,
    input  logic [NUM_CH-1:0]    tmri,
    output logic [NUM_CH-1:0]    tmo,
    output logic [NUM_CH-1:0]    irq_cmia,
    output logic [NUM_CH-1:0]    irq_cmib,
    output logic [NUM_CH-1:0]    irq_ovi
);
    // a one-channel build has no channel field, so pad the address to keep a 1-bit one
    localparam int AW_X = ADDR_W > 3 ? ADDR_W : 4;
    localparam int CH_W = AW_X - 3;

    logic [AW_X-1:0]      addr_x;
    logic [CH_W-1:0]      ch;
    logic [2:0]           off;
    logic [12:0]          presc_q;
    logic                 tick8, tick64, tick8192;
    logic [BIT_WIDTH-1:0] rd_val [NUM_CH];
    logic [BIT_WIDTH-1:0] rdata_q, rdata_d;

    assign addr_x   = AW_X'(addr);
    assign ch       = addr_x[AW_X-1:3];
    assign off      = addr_x[2:0];
    assign tick8    = &presc_q[2:0];
    assign tick64   = &presc_q[5:0];
    assign tick8192 = &presc_q;
    assign rdata    = rdata_q;

    // free-running prescaler shared by every channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_q + 1'b1;
    end

    // read data is captured on rd_en and held otherwise; absent channels read 0
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            for (int i = 0; i < NUM_CH; i++)
                if (ch == CH_W'(i)) rdata_d = rd_val[i];
        end
    end

    // read data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [BIT_WIDTH-1:0] tcnt_q, tcnt_d, tcora_q, tcora_d, tcorb_q, tcorb_d;
        logic [7:0]           tcr_q, tcr_d, src;
        logic [3:0]           os_q, os_d;
        logic [2:0]           ci_q, ri_q;
        logic [4:0]           wsel;
        logic [1:0]           act;
        logic ovf_q, ovf_d, cmfa_q, cmfa_d, cmfb_q, cmfb_d, tmo_q, tmo_d;
        logic eqa_q, eqb_q, pend_q, pend_d, wrap_q, wrap_d;
        logic sel, ci_rise, ci_fall, tick, ma, mb, clr_m, clr_r, clr_t;

        assign sel     = ch == CH_W'(g);
        assign wsel    = (wr_en && sel) ? 5'(1) << off : '0;
        // ci_q/ri_q: [0],[1] synchroniser, [2] previous synchronised value for edge detection
        assign ci_rise = ci_q[1] & ~ci_q[2];
        assign ci_fall = ~ci_q[1] & ci_q[2];
        assign src     = {1'b1, ci_rise | ci_fall, ci_fall, ci_rise, tick8192, tick64, tick8, 1'b0};
        assign tick    = src[tcr_q[2:0]];
        assign ma      = (tcnt_q == tcora_q) & ~eqa_q;
        assign mb      = (tcnt_q == tcorb_q) & ~eqb_q;
        assign clr_m   = (tcr_q[4:3] == 2'b01 & ma) | (tcr_q[4:3] == 2'b10 & mb);
        assign clr_r   = (tcr_q[4:3] == 2'b11) & ri_q[1] & ~ri_q[2];
        // a match arms the clear; the first tick from then on zeroes instead of counting
        assign clr_t   = tick & (pend_q | clr_m);
        assign act     = (ma && os_q[1:0] != 2'b00) ? os_q[1:0] : mb ? os_q[3:2] : 2'b00;

        assign tmo[g]      = tmo_q;
        assign irq_cmia[g] = cmfa_q & tcr_q[5];
        assign irq_cmib[g] = cmfb_q & tcr_q[6];
        assign irq_ovi[g]  = ovf_q & tcr_q[7];
        assign rd_val[g]   = off == 3'd0 ? BIT_WIDTH'(tcr_q) :
                             off == 3'd1 ? BIT_WIDTH'({cmfb_q, cmfa_q, ovf_q, 1'b0, os_q}) :
                             off == 3'd2 ? tcora_q :
                             off == 3'd3 ? tcorb_q :
                             off == 3'd4 ? tcnt_q : '0;

        // next state: bus writes, count/clear priority, sticky flags and pin action
        always_comb begin
            tcr_d   = wsel[0] ? wdata[7:0] : tcr_q;
            os_d    = wsel[1] ? wdata[3:0] : os_q;
            tcora_d = wsel[2] ? wdata : tcora_q;
            tcorb_d = wsel[3] ? wdata : tcorb_q;
            tcnt_d  = wsel[4] ? wdata : (clr_r || clr_t) ? '0 : tick ? tcnt_q + 1'b1 : tcnt_q;
            wrap_d  = !wsel[4] && !clr_r && !clr_t && tick && (&tcnt_q);
            pend_d  = (wsel[4] || clr_r || tick) ? 1'b0 : pend_q | clr_m;
            ovf_d   = wrap_q | (ovf_q & ~(wsel[1] & ~wdata[5]));
            cmfa_d  = ma | (cmfa_q & ~(wsel[1] & ~wdata[6]));
            cmfb_d  = mb | (cmfb_q & ~(wsel[1] & ~wdata[7]));
            tmo_d   = act == 2'b01 ? 1'b0 : act == 2'b10 ? 1'b1 : act == 2'b11 ? ~tmo_q : tmo_q;
        end

        // channel state registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tcnt_q  <= '0;
                tcora_q <= '1;
                tcorb_q <= '1;
                tcr_q   <= '0;
                os_q    <= '0;
                ovf_q   <= 1'b0;
                cmfa_q  <= 1'b0;
                cmfb_q  <= 1'b0;
                tmo_q   <= 1'b0;
                eqa_q   <= 1'b0;
                eqb_q   <= 1'b0;
                pend_q  <= 1'b0;
                wrap_q  <= 1'b0;
                ci_q    <= '0;
                ri_q    <= '0;
            end else begin
                tcnt_q  <= tcnt_d;
                tcora_q <= tcora_d;
                tcorb_q <= tcorb_d;
                tcr_q   <= tcr_d;
                os_q    <= os_d;
                ovf_q   <= ovf_d;
                cmfa_q  <= cmfa_d;
                cmfb_q  <= cmfb_d;
                tmo_q   <= tmo_d;
                eqa_q   <= tcnt_q == tcora_q;
                eqb_q   <= tcnt_q == tcorb_q;
                pend_q  <= pend_d;
                wrap_q  <= wrap_d;
                ci_q    <= {ci_q[1:0], tmci[g]};
                ri_q    <= {ri_q[1:0], tmri[g]};
            end
        end
    end
endmodule

// File: tb/tb_tmr_channel_array.sv
// tb_tmr_channel_array: directed and random checks of tmr_channel_array against a behavioural model
module tb_tmr_channel_array;
    localparam int BW = 16, NC = 3, AW = 5;

    logic          clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [BW-1:0] wdata = '0, rdata;
    logic [NC-1:0] tmci = '0, tmri = '0, tmo, irq_cmia, irq_cmib, irq_ovi;
    int errors = 0, checks = 0;

    int            pm;
    logic [BW-1:0] m_cnt [NC], m_cora [NC], m_corb [NC];
    logic [BW-1:0] m_rdata;
    logic [7:0]    m_tcr [NC];
    logic [3:0]    m_os [NC];
    logic [NC-1:0] m_ovf, m_cfa, m_cfb, m_tmo, m_seena, m_seenb, m_clr_due, m_ovf_due;
    logic [NC-1:0] ci1, ci2, ci3, ri1, ri2, ri3;

    tmr_channel_array #(.BIT_WIDTH(BW), .NUM_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .tmci(tmci), .tmri(tmri), .tmo(tmo),
        .irq_cmia(irq_cmia), .irq_cmib(irq_cmib), .irq_ovi(irq_ovi)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pm = 0;
        m_rdata = '0;
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = '0; m_cora[c] = '1; m_corb[c] = '1; m_tcr[c] = '0; m_os[c] = '0;
        end
        {m_ovf, m_cfa, m_cfb, m_tmo, m_seena, m_seenb, m_clr_due, m_ovf_due} = '0;
        {ci1, ci2, ci3, ri1, ri2, ri3} = '0;
    endtask

    function automatic logic [BW-1:0] mread(input int c, input int o);
        case (o)
            0: return BW'(m_tcr[c]);
            1: return BW'({m_cfb[c], m_cfa[c], m_ovf[c], 1'b0, m_os[c]});
            2: return m_cora[c];
            3: return m_corb[c];
            4: return m_cnt[c];
            default: return '0;
        endcase
    endfunction

    function automatic logic [NC-1:0] men(input int b);
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = m_tcr[c][b];
        return v;
    endfunction

    // advance the model across one rising edge using the inputs currently driven
    task automatic model_edge();
        int ac, ao;
        logic [NC-1:0] rise, fall, rrise;
        ac = int'(addr[4:3]);
        ao = int'(addr[2:0]);
        rise = ci2 & ~ci3;
        fall = ~ci2 & ci3;
        rrise = ri2 & ~ri3;
        if (rd_en) m_rdata = ac < NC ? mread(ac, ao) : '0;
        for (int c = 0; c < NC; c++) begin
            bit w, tk, ea, eb, ma, mb, cm, cr, ct;
            logic [1:0] a;
            w = wr_en && ac == c;
            case (m_tcr[c][2:0])
                3'd0: tk = 0;
                3'd1: tk = pm % 8 == 7;
                3'd2: tk = pm % 64 == 63;
                3'd3: tk = pm % 8192 == 8191;
                3'd4: tk = rise[c];
                3'd5: tk = fall[c];
                3'd6: tk = rise[c] | fall[c];
                default: tk = 1;
            endcase
            ea = m_cnt[c] == m_cora[c];
            eb = m_cnt[c] == m_corb[c];
            ma = ea && !m_seena[c];
            mb = eb && !m_seenb[c];
            cm = (m_tcr[c][4:3] == 2'd1 && ma) || (m_tcr[c][4:3] == 2'd2 && mb);
            cr = m_tcr[c][4:3] == 2'd3 && rrise[c];
            ct = tk && (m_clr_due[c] || cm);
            a = (ma && m_os[c][1:0] != 2'd0) ? m_os[c][1:0] : mb ? m_os[c][3:2] : 2'd0;
            if (a == 2'd1) m_tmo[c] = 0;
            else if (a == 2'd2) m_tmo[c] = 1;
            else if (a == 2'd3) m_tmo[c] = !m_tmo[c];
            if (w && ao == 1) begin
                if (!wdata[5]) m_ovf[c] = 0;
                if (!wdata[6]) m_cfa[c] = 0;
                if (!wdata[7]) m_cfb[c] = 0;
                m_os[c] = wdata[3:0];
            end
            m_ovf[c] = m_ovf[c] | m_ovf_due[c];
            m_cfa[c] = m_cfa[c] | ma;
            m_cfb[c] = m_cfb[c] | mb;
            m_ovf_due[c] = 0;
            m_seena[c] = ea;
            m_seenb[c] = eb;
            if (w && ao == 4) begin
                m_cnt[c] = wdata; m_clr_due[c] = 0;
            end else if (cr || ct) begin
                m_cnt[c] = '0; m_clr_due[c] = 0;
            end else if (tk) begin
                m_ovf_due[c] = m_cnt[c] == '1;
                m_cnt[c] = m_cnt[c] + 1'b1;
                m_clr_due[c] = 0;
            end else m_clr_due[c] = m_clr_due[c] | cm;
            if (w && ao == 0) m_tcr[c] = wdata[7:0];
            if (w && ao == 2) m_cora[c] = wdata;
            if (w && ao == 3) m_corb[c] = wdata;
        end
        pm = (pm + 1) % 8192;
        ci3 = ci2; ci2 = ci1; ci1 = tmci;
        ri3 = ri2; ri2 = ri1; ri1 = tmri;
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        wr_en = 0;
        rd_en = 0;
        chk("tmo", tmo, m_tmo);
        chk("irq_cmia", irq_cmia, m_cfa & men(5));
        chk("irq_cmib", irq_cmib, m_cfb & men(6));
        chk("irq_ovi", irq_ovi, m_ovf & men(7));
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic wr(input int c, input int o, input logic [BW-1:0] d);
        addr = AW'(c * 8 + o);
        wdata = d;
        wr_en = 1;
        step();
    endtask

    task automatic rd(input int c, input int o, input logic [BW-1:0] e, input string tag);
        addr = AW'(c * 8 + o);
        rd_en = 1;
        step();
        chk(tag, rdata, e);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("reset_tmo", tmo, 0);
        chk("reset_irq", {irq_cmia, irq_cmib, irq_ovi}, 0);
        chk("reset_rdata", rdata, 0);
        rd(0, 0, 16'h0000, "reset_tcr");
        rd(0, 1, 16'h0000, "reset_tcsr");
        rd(0, 2, 16'hFFFF, "reset_tcora");
        rd(0, 3, 16'hFFFF, "reset_tcorb");
        rd(0, 4, 16'h0000, "reset_tcnt");
        rd(0, 5, 16'h0000, "off5_zero");
        rd(3, 2, 16'h0000, "absent_channel");

        wr(1, 0, 16'hFF40);
        rd(1, 0, 16'h0040, "tcr_upper_bits");
        wr(1, 1, 16'hFFFF);
        rd(1, 1, 16'h000F, "tcsr_no_sw_set");
        wr(1, 0, 16'h0000);
        wr(1, 1, 16'h0000);

        wr(0, 2, 16'd5);
        wr(0, 1, 16'h0003);
        wr(0, 0, 16'h002F);
        repeat (6) step();
        chk("cmfa_toggle_tmo", tmo[0], 1);
        chk("cmfa_irq_set", irq_cmia[0], 1);
        wr(0, 1, 16'h0003);
        chk("cmfa_irq_cleared", irq_cmia[0], 0);
        wr(0, 0, 16'h0000);
        rd(0, 4, 16'd2, "clear_on_a_count");

        while (pm % 8 != 7) step();
        wr(1, 4, 16'hFFFE);
        wr(1, 0, 16'h0081);
        repeat (15) step();
        wr(1, 0, 16'h0080);
        chk("ovf_irq", irq_ovi[1], 1);
        rd(1, 4, 16'h0000, "ovf_wrap_tcnt");
        rd(1, 1, 16'h00E0, "ovf_tcsr");
        wr(1, 0, 16'h0000);
        chk("ovf_irq_masked", irq_ovi[1], 0);

        wr(2, 0, 16'h0004);
        tmci[2] = 1;
        step();
        step();
        rd(2, 4, 16'd0, "tmci_before_latency");
        rd(2, 4, 16'd1, "tmci_after_latency");
        tmci[2] = 0;
        repeat (4) step();
        repeat (2) begin
            tmci[2] = 1;
            repeat (4) step();
            tmci[2] = 0;
            repeat (4) step();
        end
        rd(2, 4, 16'd3, "tmci_rising_count");
        wr(2, 4, 16'd0);
        wr(2, 0, 16'h0006);
        repeat (3) begin
            tmci[2] = 1;
            repeat (4) step();
            tmci[2] = 0;
            repeat (4) step();
        end
        rd(2, 4, 16'd6, "tmci_both_count");

        wr(2, 0, 16'h001F);
        wr(2, 4, 16'h0040);
        tmri[2] = 1;
        repeat (3) step();
        rd(2, 4, 16'd0, "tmri_clear");
        tmri[2] = 0;
        wr(2, 0, 16'h0000);

        wr(0, 2, 16'h0100);
        wr(0, 3, 16'h0100);
        wr(0, 1, 16'h0009);
        wr(0, 4, 16'h00FF);
        wr(0, 0, 16'h0007);
        step();
        wr(0, 0, 16'h0000);
        chk("a_wins_tmo", tmo[0], 0);
        rd(0, 1, 16'h00C9, "a_wins_flags");

        for (int i = 0; i < 1500; i++) begin
            int r, o;
            if ($urandom_range(0, 3) == 0) tmci = tmci ^ NC'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) tmri = tmri ^ NC'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            addr = AW'($urandom);
            o = int'(addr[2:0]);
            if (r < 3) begin
                wr_en = 1;
                wdata = (o >= 2 && o <= 4) ? BW'($urandom_range(0, 12)) : BW'($urandom);
            end
            if (r >= 2 && r < 6) rd_en = 1;
            step();
        end

        tmci = '0;
        tmri = '0;
        #2 rst_n = 0;
        #1;
        chk("async_reset_tmo", tmo, 0);
        chk("async_reset_irq", {irq_cmia, irq_cmib, irq_ovi}, 0);
        chk("async_reset_rdata", rdata, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        rd(0, 2, 16'hFFFF, "after_reset_tcora");
        rd(2, 4, 16'h0000, "after_reset_tcnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tmr_channel_array.md
# tmr_channel_array

Parametrised multi-channel compare-match timer, successor to the fixed 4-channel 8-bit timer. It provides NUM_CH independent up-counters of BIT_WIDTH bits. Each channel has a selectable internal or external count source, two compare registers (A/B), a configurable counter clear, TMO pin actions, status flags and interrupt requests. It sits on the peripheral register bus and drives the TMO pins and the interrupt controller.

## Interface
- BIT_WIDTH, 8: width of TCNT/TCORA/TCORB and of the data bus; minimum 8.
- NUM_CH, 4: number of channels; minimum 1.
- ADDR_W, $clog2(NUM_CH)+3: register address width.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, one cycle.
- rd_en  in  1  register read strobe, one cycle.
- addr  in  ADDR_W  {channel, offset[2:0]}.
- wdata  in  BIT_WIDTH  write data.
- rdata  out  BIT_WIDTH  read data; registered, valid the cycle after rd_en, held otherwise.
- tmci  in  NUM_CH  external count clock per channel; asynchronous.
- tmri  in  NUM_CH  external counter reset per channel; asynchronous.
- tmo  out  NUM_CH  compare-match output pins.
- irq_cmia / irq_cmib / irq_ovi  out  NUM_CH each  interrupt levels: flag AND enable.

## Operation
- Offsets: 0 TCR, 1 TCSR, 2 TCORA, 3 TCORB, 4 TCNT. Offsets 5-7 read 0 and ignore writes. A channel index ≥ NUM_CH reads 0.
- TCR[2:0] CKS selects the count tick:
  - 000 stopped
  - 001 clk/8
  - 010 clk/64
  - 011 clk/8192
  - 100 tmci rising edge
  - 101 tmci falling edge
  - 110 tmci both edges
  - 111 every clk
- TCR[4:3] CCLR: 00 no clear, 01 clear on match A, 10 clear on match B, 11 clear on tmri rising edge.
- TCR[5] CMIEA, TCR[6] CMIEB, TCR[7] OVIE. Bits above 7 read 0.
- TCSR[1:0] OSA and TCSR[3:2] OSB set the TMO action: 00 none, 01 drive 0, 10 drive 1, 11 toggle.
- TCSR[5] OVF, TCSR[6] CMFA, TCSR[7] CMFB.
  - A written 0 clears a flag; a written 1 leaves it unchanged. Software can never set a flag.
  - TCSR[4] reads 0.
- Prescaler: one free-running 13-bit counter shared by all channels; it resets to 0.
  - The clk/8 tick fires when presc[2:0]==7.
  - The clk/64 tick fires when presc[5:0]==63.
  - The clk/8192 tick fires when presc==8191.
- tmci and tmri pass through 2-flop synchronisers, then edge detection on the synchronised value.
- Count: on a tick, TCNT <= TCNT+1 (mod 2^BIT_WIDTH).
  - On a tick with TCNT==all-ones, TCNT wraps to 0 and OVF is set.
- Match A: the first cycle in which TCNT==TCORA (equality rising edge) is a match-A event. Match B is defined the same way with TCORB.
  - A match event sets CMFx and applies OSx to tmo.
  - Equality produced by a CPU write to TCNT or TCORx also counts as an event.
- Clear on match: the next tick after a match sets TCNT to 0 instead of incrementing. OVF is not set in that case, even if TCORx is all-ones.
- Clear on tmri: TCNT is set to 0 on the cycle the edge is detected, regardless of the tick.

## Timing
- Reset values: TCNT 0, TCORA/TCORB all-ones, TCR 0, TCSR 0, tmo 0, rdata 0, all irq 0, prescaler 0, synchronisers 0.
- Tick to TCNT update: TCNT updates on the same edge the tick is sampled.
- Match and overflow latency:
  - A flag sets 1 cycle after TCNT reaches the match or wrap value.
  - tmo updates on the same edge as the flag.
  - irq follows the flag combinationally.
- tmci/tmri pin edge to effect: 3 clk cycles (2 synchroniser stages plus 1 edge-detect stage).
- Simultaneous events, in priority order:
  - A CPU write to TCNT beats a tick or clear in the same cycle.
  - A flag set by hardware beats a software clear of that flag in the same cycle.
  - Match A and match B in the same cycle: the OSA action wins if OSA≠00, otherwise the OSB action applies. Both flags set.
  - tmri clear and a tick in the same cycle: the clear wins.
- Writing TCR mid-count changes the source starting with the next cycle. TCNT is not altered.
- Asserting rst_n low at any time returns all state to reset values immediately.

## Test plan
- After reset, read all offsets of channel 0 → TCR=0, TCSR=0, TCORA=TCORB=0xFF, TCNT=0, tmo=0.
- CKS=111, CCLR=01, TCORA=5, OSA=11 → TCNT sequence 0..5,0..5. tmo toggles 1 cycle after each TCNT==5. CMFA is set. With CMIEA=1, irq_cmia is high until TCSR[6] is written 0.
- CKS=001, TCNT preset to 0xFE → increments every 8 clk. After the second tick TCNT=0 and OVF=1. irq_ovi=1 only if OVIE=1.
- CKS=100, pulse tmci high for 4 clk, 3 times → TCNT=3; each increment lands 3 cycles after the rising edge. Repeat with CKS=110 → TCNT=6.
- CCLR=11, TCNT=0x40 running → a tmri rising edge zeroes TCNT 3 cycles later. Zeroing also holds with a same-cycle tick.
- NUM_CH=2, BIT_WIDTH=16, TCORA=TCORB=0x0100, OSA=01, OSB=10 → at the match both CMFA and CMFB are set and tmo=0 (A wins). Channel 1 stays untouched throughout.
